// File: rtl/term_write_arbiter_if.sv
// Character-input bus of the terminal write arbiter: CPU FIFO port, aux
// requester handshake, terminal strobe and status outputs.
interface term_write_arbiter_if #(
    parameter int CNT_W = 3
);
    logic             cpu_we;
    logic [7:0]       cpu_data;
    logic             cpu_busy;
    logic             ovf;
    logic             ovf_clr;
    logic             aux_req;
    logic [7:0]       aux_data;
    logic             aux_ack;
    logic             tready;
    logic             te;
    logic [6:0]       ti;
    logic [CNT_W-1:0] fifo_count;

    // Master drives requests and terminal readiness; slave is the arbiter.
    modport master (
        output cpu_we, cpu_data, ovf_clr, aux_req, aux_data, tready,
        input  cpu_busy, ovf, aux_ack, te, ti, fifo_count
    );

    modport slave (
        input  cpu_we, cpu_data, ovf_clr, aux_req, aux_data, tready,
        output cpu_busy, ovf, aux_ack, te, ti, fifo_count
    );
endinterface

// File: rtl/term_write_arbiter.sv
// Buffers CPU $D012 writes in a FIFO and forwards one character per tready.
// Define TERM_ARB_AUX_EN to add the round-robin aux requester.
module term_write_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    term_write_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [6:0]       ti_q, ti_d;

    logic             cpu_pend;
    logic             grant_cpu;
    logic             grant_aux;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [7:0]       head;

`ifdef TERM_ARB_AUX_EN
    typedef enum logic {
        LAST_CPU,
        LAST_AUX
    } last_t;

    last_t last_q, last_d;
    logic  aux_pend;

    assign aux_pend = bus.aux_req;
`else
    logic  aux_unused;

    assign aux_unused = ^{bus.aux_req, bus.aux_data};
`endif

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign cpu_pend = (count_q != '0);
    assign head     = mem_q[rd_ptr_q];

    // Grant decision and issue sequencing; tready is only looked at in IDLE.
    always_comb begin
        state_d   = state_q;
        ti_d      = ti_q;
        grant_cpu = 1'b0;
        grant_aux = 1'b0;
`ifdef TERM_ARB_AUX_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.tready) begin
`ifdef TERM_ARB_AUX_EN
                    if (cpu_pend && (!aux_pend || last_q == LAST_AUX)) begin
                        grant_cpu = 1'b1;
                    end else if (aux_pend) begin
                        grant_aux = 1'b1;
                    end
`else
                    grant_cpu = cpu_pend;
`endif
                end
                if (grant_cpu) begin
                    ti_d    = head[6:0];
                    state_d = ISSUE;
`ifdef TERM_ARB_AUX_EN
                    last_d  = LAST_CPU;
`endif
                end
                if (grant_aux) begin
                    ti_d    = bus.aux_data[6:0];
                    state_d = ISSUE;
`ifdef TERM_ARB_AUX_EN
                    last_d  = LAST_AUX;
`endif
                end
            end
            ISSUE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    always_comb begin
        pop      = grant_cpu;
        push     = bus.cpu_we && (!full || pop);
        drop     = bus.cpu_we && full && !pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ti_q     <= '0;
`ifdef TERM_ARB_AUX_EN
            last_q   <= LAST_AUX;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ti_q     <= ti_d;
`ifdef TERM_ARB_AUX_EN
            last_q   <= last_d;
`endif
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.cpu_data;
        end
    end

    assign bus.te         = (state_q == ISSUE);
    assign bus.ti         = ti_q;
    assign bus.cpu_busy   = full;
    assign bus.ovf        = ovf_q;
    assign bus.fifo_count = count_q;
`ifdef TERM_ARB_AUX_EN
    assign bus.aux_ack    = grant_aux && reset;
`else
    assign bus.aux_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_term_write_arbiter.sv
// Scoreboard bench for term_write_arbiter: a queue-based model predicts each
// terminal write, and a negedge monitor pops and compares what the DUT issues.
module tb_term_write_arbiter;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef TERM_ARB_AUX_EN
    localparam bit AUX_EN = 1'b1;
`else
    localparam bit AUX_EN = 1'b0;
`endif

    typedef struct {
        logic [6:0] ch;
        int         cyc;
    } teExp_t;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    always #5 clk = ~clk;

    term_write_arbiter_if #(.CNT_W(CW)) bus ();

    term_write_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .reset (rstN),
        .bus   (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    teExp_t     teQ[$];
    logic [7:0] cpuQ[$];
    bit         modelIssue   = 1'b0;
    bit         modelLastAux = 1'b1;
    bit         modelOvf     = 1'b0;
    logic [6:0] modelTi      = '0;
    logic       obsAck       = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h cycle=%0d",
                     name, actual, expected, cyc);
        end
    endtask

    // Drive one cycle of inputs; called and returns at posedge+1.
    task automatic applyStimulus(input bit we, input logic [7:0] d, input bit tr,
                                 input bit areq, input logic [7:0] ad, input bit clr);
        bus.cpu_we   = we;
        bus.cpu_data = d;
        bus.tready   = tr;
        bus.aux_req  = areq;
        bus.aux_data = ad;
        bus.ovf_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 0, 8'h00, 0);
    endtask

    task automatic pulseReset();
        rstN = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    // Reference model: the CPU FIFO is a plain queue, grants follow the
    // round-robin rule, and every grant schedules a te one cycle later.
    initial begin
        bit         gCpu, gAux, dropped;
        logic [7:0] b;
        forever begin
            @(posedge clk or negedge rstN);
            if (!rstN) begin
                teQ.delete();
                cpuQ.delete();
                modelIssue   = 1'b0;
                modelLastAux = 1'b1;
                modelOvf     = 1'b0;
                modelTi      = '0;
            end else begin
                gCpu    = 1'b0;
                gAux    = 1'b0;
                dropped = 1'b0;
                if (modelIssue) begin
                    modelIssue = 1'b0;
                end else if (bus.tready) begin
                    if (cpuQ.size() > 0 && AUX_EN && bus.aux_req) begin
                        if (modelLastAux) gCpu = 1'b1;
                        else              gAux = 1'b1;
                    end else if (cpuQ.size() > 0) begin
                        gCpu = 1'b1;
                    end else if (AUX_EN && bus.aux_req) begin
                        gAux = 1'b1;
                    end
                end
                checkOutput("auxAck", {31'd0, obsAck}, {31'd0, gAux});
                if (gCpu) begin
                    b = cpuQ.pop_front();
                    modelLastAux = 1'b0;
                end
                if (gAux) begin
                    b = bus.aux_data;
                    modelLastAux = 1'b1;
                end
                if (gCpu || gAux) begin
                    modelTi    = b[6:0];
                    modelIssue = 1'b1;
                    teQ.push_back('{ch: b[6:0], cyc: cyc + 1});
                end
                if (bus.cpu_we) begin
                    if (cpuQ.size() < DEPTH) cpuQ.push_back(bus.cpu_data);
                    else                     dropped = 1'b1;
                end
                if (dropped)          modelOvf = 1'b1;
                else if (bus.ovf_clr) modelOvf = 1'b0;
                cyc++;
            end
        end
    end

    // Monitor: compares status each negedge and pops the scoreboard on te.
    initial begin
        bit     expTe;
        teExp_t e;
        forever begin
            @(negedge clk);
            obsAck = bus.aux_ack;
            checkOutput("fifoCount", 32'(bus.fifo_count), cpuQ.size());
            checkOutput("cpuBusy", {31'd0, bus.cpu_busy}, {31'd0, cpuQ.size() == DEPTH});
            checkOutput("ovf", {31'd0, bus.ovf}, {31'd0, modelOvf});
            checkOutput("tiHold", 32'(bus.ti), 32'(modelTi));
            expTe = (teQ.size() > 0) && (teQ[0].cyc == cyc);
            checkOutput("te", {31'd0, bus.te}, {31'd0, expTe});
            if (expTe) begin
                e = teQ.pop_front();
                if (bus.te) checkOutput("tiIssued", 32'(bus.ti), 32'(e.ch));
            end
        end
    end

    initial begin
        bit         auxReq  = 1'b0;
        logic [7:0] auxData = 8'h00;
        bus.cpu_we   = 1'b0;
        bus.cpu_data = 8'h00;
        bus.tready   = 1'b0;
        bus.aux_req  = 1'b0;
        bus.aux_data = 8'h00;
        bus.ovf_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
        idle(2);

        $display("[TB] three CPU bytes, three spaced tready pulses");
        applyStimulus(1, 8'hC1, 0, 0, 8'h00, 0);
        applyStimulus(1, 8'hC2, 0, 0, 8'h00, 0);
        applyStimulus(1, 8'hC3, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 8'h00, 1, 0, 8'h00, 0);
            idle(9);
        end

        $display("[TB] overflow on the fifth write, clear, drain");
        for (int i = 1; i <= 5; i++) applyStimulus(1, 8'(8'h80 + i), 0, 0, 8'h00, 0);
        idle(2);
        applyStimulus(0, 8'h00, 0, 0, 8'h00, 1);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 8'h00, 1, 0, 8'h00, 0);
            idle(2);
        end

        $display("[TB] CPU and aux sharing");
        pulseReset();
        applyStimulus(1, 8'h31, 0, 0, 8'h00, 0);
        applyStimulus(1, 8'h32, 0, 1, 8'h5A, 0);
        applyStimulus(0, 8'h00, 1, 1, 8'h5A, 0);
        applyStimulus(0, 8'h00, 0, 1, 8'h5A, 0);
        applyStimulus(0, 8'h00, 0, 1, 8'h5A, 0);
        applyStimulus(0, 8'h00, 1, 1, 8'h5A, 0);
        idle(2);
        applyStimulus(0, 8'h00, 1, 0, 8'h00, 0);
        idle(3);

        $display("[TB] push into a full FIFO alongside a pop");
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'(8'h41 + i), 0, 0, 8'h00, 0);
        applyStimulus(1, 8'h7E, 1, 0, 8'h00, 0);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 8'h00, 1, 0, 8'h00, 0);
            idle(2);
        end

        $display("[TB] reset during the issue cycle");
        applyStimulus(1, 8'h55, 0, 0, 8'h00, 0);
        applyStimulus(1, 8'h56, 1, 0, 8'h00, 0);
        pulseReset();
        applyStimulus(0, 8'h00, 1, 0, 8'h00, 0);
        idle(3);

        $display("[TB] aux request held across two tready pulses, FIFO empty");
        applyStimulus(0, 8'h00, 0, 1, 8'h21, 0);
        applyStimulus(0, 8'h00, 1, 1, 8'h21, 0);
        applyStimulus(0, 8'h00, 0, 1, 8'h21, 0);
        applyStimulus(0, 8'h00, 1, 1, 8'h21, 0);
        idle(3);

        $display("[TB] randomized traffic");
        pulseReset();
        for (int i = 0; i < 3000; i++) begin
            if (auxReq && obsAck) begin
                auxReq = 1'b0;
            end else if (!auxReq && $urandom_range(0, 3) == 0) begin
                auxReq  = 1'b1;
                auxData = 8'($urandom);
            end else if (auxReq && $urandom_range(0, 15) == 0) begin
                auxReq = 1'b0;
            end
            applyStimulus($urandom_range(0, 2) == 0, 8'($urandom),
                          $urandom_range(0, 2) == 0, auxReq, auxData,
                          $urandom_range(0, 9) == 0);
        end
        idle(4);
        checkOutput("teQueueDrained", teQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/term_write_arbiter.md
# term_write_arbiter

Sits between the 6502 bus decode and `signetics_term`, and owns the terminal's character input port. The CPU writes to `$D012`, and those writes are buffered in a small FIFO. A second requester (aux: serial echo, boot/diagnostic text) gets shared access under a round-robin policy. Exactly one character goes to the terminal per `tready` pulse. The block also supplies the display-status bit the CPU reads at `$D012`.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: CPU FIFO depth. Must be a power of 2, from 2 to 16.
- `CNT_W`, default 3: width of `fifo_count`. Must hold 0..`FIFO_DEPTH`.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_we`  in  1  one-cycle CPU write strobe (decode of `WE && AB==16'hd012`).
- `cpu_data`  in  8  CPU write data (`DO`).
- `cpu_busy`  out  1  FIFO full; drives bit 7 of the `$D012` read.
- `ovf`  out  1  sticky flag: a CPU write was dropped.
- `ovf_clr`  in  1  clears `ovf`.
- `aux_req`  in  1  aux request level; hold until `aux_ack`.
- `aux_data`  in  8  aux character; stable while `aux_req`=1.
- `aux_ack`  out  1  one-cycle acknowledge.
- `tready`  in  1  terminal ready pulse from `signetics_term`.
- `te`  out  1  terminal write enable (one cycle per character).
- `ti`  out  7  character to the terminal (bit 7 stripped).
- `fifo_count`  out  `CNT_W`  current FIFO occupancy.

## Operation
FIFO:
- Push when `cpu_we`=1 and occupancy < `FIFO_DEPTH`, or when a pop happens in the same cycle (full + push + pop leaves the count unchanged).
- A push while full with no pop drops the data and sets `ovf`=1.
- `ovf_clr` clears `ovf`. If `ovf_clr` and a new overflow occur in the same cycle, the overflow wins (`ovf` stays 1).
- Pointers wrap modulo `FIFO_DEPTH`.
- `cpu_busy` = (occupancy == `FIFO_DEPTH`).

State machine: IDLE, ISSUE.
- IDLE: in a cycle where `tready`=1 and at least one requester is pending, grant. The granted data is registered into `ti` (`data & 7'h7f`) and the state moves to ISSUE.
  - CPU grant: pops the FIFO head.
  - Aux grant: pulses `aux_ack` in this same cycle.
- ISSUE: `te`=1 for exactly one cycle, then back to IDLE. `tready` is ignored while in ISSUE.
- If `tready`=1 and nothing is pending: stay in IDLE, `te`=0.

Arbitration:
- A `last` pointer records the most recent grantee. When both requesters are pending, the one not in `last` is granted. A single pending requester is always granted.
- `last` resets to AUX, so the CPU wins the first tie.
- `aux_req` is sampled only in the grant cycle. Dropping it before the grant withdraws the request with no ack. Dropping it after the ack has no effect.
- `ti` holds its value between issues. All bytes are forwarded as-is after bit-7 masking; CR and control-code filtering is the terminal's job.

Reset (`reset`=0) takes effect immediately:
- `te`=0, `ti`=0, `aux_ack`=0, `ovf`=0, `cpu_busy`=0, `fifo_count`=0.
- State = IDLE, `last` = AUX, FIFO emptied.
- A reset asserted during ISSUE aborts the write; the character is lost.

## Timing
- `tready` sampled high in cycle N gives `te`=1 in cycle N+1 with `ti` valid in that same cycle. `aux_ack` is in cycle N.
- Successive issues are at least 2 cycles apart. In practice the terminal makes them one video line apart.
- CPU write to `fifo_count`/`cpu_busy` update: 1 cycle.
- Latency from an empty FIFO to the terminal: next `tready` pulse + 1 cycle.

## Configuration
- `TERM_ARB_AUX_EN` defined: the aux requester and round-robin arbitration are compiled in as described above.
- `TERM_ARB_AUX_EN` undefined:
  - `aux_req` and `aux_data` are ignored; `aux_ack` is tied to 0.
  - The `last` pointer and arbitration logic are removed, and every slot is given to the CPU FIFO.
  - Port list is unchanged.

## Test plan
- Reset, then write 3 CPU bytes `8'hC1`,`8'hC2`,`8'hC3`, then 3 `tready` pulses 10 cycles apart. Required: `te` pulses carrying `ti`=`7'h41`,`7'h42`,`7'h43` in order, each 1 cycle after its `tready`; `fifo_count` goes 3→0.
- 5 CPU writes (`FIFO_DEPTH`=4) with no `tready`. Required: `cpu_busy`=1 after the 4th; the 5th is dropped and `ovf`=1; `ovf_clr` then gives `ovf`=0; draining delivers only the first 4 bytes.
- FIFO holds 2 bytes and `aux_req`=1 with `aux_data`=`8'h5A`, then 3 `tready` pulses. Required order: CPU, AUX (`ti`=`7'h5A`, `aux_ack` in the grant cycle), CPU.
- FIFO full, with `cpu_we` in the same cycle as a `tready` pop. Required: push accepted, `fifo_count` stays 4, `ovf` stays 0.
- `reset` low during the ISSUE cycle. Required: `te` drops immediately, `fifo_count`=0, and the next `tready` after release produces no `te`.
- With `TERM_ARB_AUX_EN` undefined: `aux_req`=1 held through 2 `tready` pulses. Required: `aux_ack` never asserts and no `te` is issued.
